mem_access_ctrl: RTL
====================

# mem_access_ctrl

Initiator-side sequencer for the MAR/MDR/RAM memory subsystem. Accepts one load or store request at a time over a valid/ready handshake. Generates the cycle-by-cycle control strobes needed to perform the access: MAR load, MDR mux select, MDR load, RAM read and RAM write. It drives the address or store data onto the datapath bus and returns load data with a response handshake. It sits between the CPU control unit and the memory subsystem, and replaces hand-sequenced control-signal testbench stimulus.

## Interface

**Parameters**
- ADDR_W, 9: RAM address width; valid addresses are 0 to 2^ADDR_W−1.
- DATA_W, 32: data and bus width.
- RAM_LAT, 1: cycles mem_read is held before the MDR captures RAM data; legal range 1–15.

**Ports**
- clk  in  1  single clock, rising edge.
- clr  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  DATA_W  byte-agnostic word address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  address out of range; no memory access was made.
- bus_out  out  DATA_W  value driven onto BusMuxOut.
- mar_in  out  1  MAR load enable.
- mdr_in  out  1  MDR load enable.
- mdr_sel  out  1  MDR mux select: 0 = bus, 1 = RAM data.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe.
- mdr_q  in  DATA_W  current MDR contents.

## Operation

**Request capture**
- On accept (req_valid & req_ready at a rising edge), register addr, we and wdata. Request inputs are ignored afterwards until the block returns to IDLE.

**FSM states and outputs**
- IDLE: req_ready=1. All strobes are 0 and bus_out=0.
  - On accept with req_addr[DATA_W-1:ADDR_W] ≠ 0, go to ERR.
  - On any other accept, go to MAR.
- MAR: bus_out=addr, mar_in=1. Next state is WMDR if we, else RD.
- WMDR: bus_out=wdata, mdr_sel=0, mdr_in=1. Next state is WR.
- WR: mem_write=1. Next state is DONE.
- RD: mem_read=1. A down-counter loaded with RAM_LAT−1 on entry; leave for RMDR when the counter reaches 0.
- RMDR: mem_read=1, mdr_sel=1, mdr_in=1. Next state is DONE.
- DONE: rsp_valid=1, rsp_err=0. rsp_rdata = mdr_q for loads and 0 for stores.
  - Hold until rsp_ready; then go to IDLE.
- ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0. Hold until rsp_ready; then go to IDLE.

**Output rules**
- Every output not listed for a state is 0 in that state.
- All outputs are decoded from registered state and registered captured fields only; there are no combinational paths from req_* or rsp_ready to outputs.
- mdr_in is never asserted in DONE, so mdr_q and rsp_rdata stay stable while rsp_valid is held.

## Timing

**Reset**
- clr low at an edge forces IDLE, clears the counter and clears the captured registers.
- While clr is low, req_ready is forced to 0. Every other output is 0 from the reset edge onward.
- Reset mid-operation (any state) aborts the request: no response is produced. Any strobe asserted in the aborted state drops after that edge.

**Latency** (accept edge = edge 0)
- Store: strobes in cycles 1–3; rsp_valid from cycle 4.
- Load: rsp_valid from cycle 3+RAM_LAT (cycle 4 when RAM_LAT=1).
- Error: rsp_valid from cycle 1.

**Throughput and handshake**
- One outstanding request.
- The earliest next accept is the edge after the rsp_valid & rsp_ready edge. IDLE lasts at least one cycle, so there is a minimum 1-cycle bubble.
- rsp_valid stays high with rsp_rdata and rsp_err unchanged until rsp_ready is sampled high.
- req_valid high while busy: not accepted, no side effects.
- req_valid and rsp_ready high in the same DONE cycle: the response completes and the request waits for IDLE.

**Boundaries**
- Address 2^ADDR_W−1 is legal. Address 2^ADDR_W raises an error.
- RAM_LAT=1 gives exactly one RD cycle; RAM_LAT=N gives N RD cycles.

## Test plan

- Reset held 3 cycles, then released:
  - while clr=0: all outputs 0;
  - cycle after release: req_ready=1, strobes 0.
- Store addr=0x1F0, wdata=0xDEADBEEF:
  - cycle 1: mar_in=1, bus_out=0x1F0;
  - cycle 2: mdr_in=1, mdr_sel=0, bus_out=0xDEADBEEF;
  - cycle 3: mem_write=1;
  - cycle 4: rsp_valid=1, rsp_rdata=0.
- Load addr=0x1F0 after that store, RAM_LAT=1 and RAM_LAT=3:
  - mem_read high for 2 and 4 cycles respectively, the last with mdr_sel=1 and mdr_in=1;
  - rsp_rdata=0xDEADBEEF at cycle 4 and cycle 6 respectively.
- Load addr=0x200: rsp_valid and rsp_err high at cycle 1, rsp_rdata=0, no strobes at any point.
- Backpressure: rsp_ready low for 5 cycles with req_valid held high.
  - rsp_valid and rsp_rdata stay stable; req_ready stays 0.
  - The next request is accepted exactly 1 cycle after the rsp_ready handshake.
- clr pulsed low during RD: the next edge enters IDLE, mem_read drops, and no rsp_valid is produced.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Initiator-side sequencer for the MAR/MDR/RAM memory subsystem: turns one
// load/store request at a time into MAR/MDR/RAM control strobes and a response.
module mem_access_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [DATA_W-1:0] bus_out,
  output logic              mar_in,
  output logic              mdr_in,
  output logic              mdr_sel,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mdr_q
);

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAR,
    S_WMDR,
    S_WR,
    S_RD,
    S_RMDR,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic              we_q;
  logic              idle_ready;
  logic              accept;
  logic              addr_bad;

  assign accept   = (state == S_IDLE) && req_valid;
  assign addr_bad = |req_addr[DATA_W-1:ADDR_W];

  always_ff @(posedge clk) begin
    if (!clr) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        we_q    <= req_we;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    idle_ready = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = '0;
    rsp_err    = 1'b0;
    bus_out    = '0;
    mar_in     = 1'b0;
    mdr_in     = 1'b0;
    mdr_sel    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state)
      S_IDLE: begin
        idle_ready = 1'b1;
        if (req_valid) state_nx = addr_bad ? S_ERR : S_MAR;
      end
      S_MAR: begin
        bus_out = addr_q;
        mar_in  = 1'b1;
        if (we_q) begin
          state_nx = S_WMDR;
        end else begin
          state_nx = S_RD;
          cnt_nx   = CNT_W'(RAM_LAT - 1);
        end
      end
      S_WMDR: begin
        bus_out  = wdata_q;
        mdr_in   = 1'b1;
        state_nx = S_WR;
      end
      S_WR: begin
        mem_write = 1'b1;
        state_nx  = S_DONE;
      end
      S_RD: begin
        mem_read = 1'b1;
        if (cnt == '0) state_nx = S_RMDR;
        else           cnt_nx   = cnt - 1'b1;
      end
      S_RMDR: begin
        mem_read = 1'b1;
        mdr_sel  = 1'b1;
        mdr_in   = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        rsp_rdata = we_q ? '0 : mdr_q;
        if (rsp_ready) state_nx = S_IDLE;
      end
      S_ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // The only output with a path from clr: ready is withheld during reset.
  assign req_ready = idle_ready && clr;

endmodule
